accum_arbiter: RTL and testbench
================================

ACCUM_ARBITER -- requirements
Module: accum_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one accumulator router port.
REQ-002 SHALL have parameters ZONE_WIDTH=2, NUM_BANKS=4, DATA_WIDTH=64, ADDR_WIDTH=9, with the same meanings as the accumulator router.
REQ-003 SHALL have parameter RD_DEPTH, default 8 (power of 2), maximum outstanding reads.
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports as follows.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 req_wr_valid / req_wr_ready  in / out  [NUM_REQ]  per-requester write handshake.
REQ-008 req_wr_zone_id, req_accum_en, req_wr_mask, req_wr_addr, req_wdata  in  [NUM_REQ] x (ZONE_WIDTH, 1, NUM_BANKS, ADDR_WIDTH, NUM_BANKS*DATA_WIDTH)  write payload.
REQ-009 req_rd_valid / req_rd_ready  in / out  [NUM_REQ]  per-requester read-command handshake.
REQ-010 req_rd_zone_id, req_rd_mask, req_rd_addr  in  [NUM_REQ] x (ZONE_WIDTH, NUM_BANKS, ADDR_WIDTH)  read payload.
REQ-011 req_rvalid  out  [NUM_REQ]  read-data return strobe; req_rdata  out  NUM_BANKS*DATA_WIDTH  shared read data.
REQ-012 m_wr_valid, m_wvalid / m_wr_ready  out / in  1  downstream write handshake; m_wvalid equals m_wr_valid.
REQ-013 m_wr_zone_id, m_accum_en, m_wr_mask, m_wr_addr, m_wdata  out  write payload to router.
REQ-014 m_rd_valid / m_rd_ready  out / in  1; m_rd_zone_id, m_rd_mask, m_rd_addr  out  read command to router.
REQ-015 m_rvalid  in  1, m_rdata  in  NUM_BANKS*DATA_WIDTH  in-order read return from router.
REQ-016 rd_outstanding  out  $clog2(RD_DEPTH)+1  count of in-flight reads; err_orphan  out  1  sticky error flag.

Function
REQ-017 Write and read channels SHALL be arbitrated independently, each by a round-robin arbiter.
REQ-018 Round-robin: highest priority SHALL be the requester after the last granted one; it SHALL update only on a completed downstream handshake.
REQ-019 When unlocked, grant SHALL be computed combinationally from the current valids (zero-cycle latency); m_*_valid = valid of the granted requester; payload muxed from it.
REQ-020 When m_X_valid=1 and m_X_ready=0, grant SHALL lock (registered) until the handshake; payload and valid SHALL stay stable.
REQ-021 req_X_ready[i] SHALL equal grant_X[i] AND m_X_ready (read additionally gated by REQ-022); non-granted readies SHALL be 0.
REQ-022 Read ID FIFO (RD_DEPTH entries, requester index): push on read handshake; when full, m_rd_valid and all req_rd_ready SHALL be 0, even if a pop occurs in the same cycle.
REQ-023 On m_rvalid with FIFO non-empty: pop head, req_rvalid[head]=1 same cycle, others 0; req_rdata = m_rdata always.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo RD_DEPTH.
REQ-025 On m_rvalid with FIFO empty: no req_rvalid; err_orphan SHALL set and hold until reset.
REQ-026 rd_outstanding SHALL equal FIFO occupancy (0..RD_DEPTH).
REQ-027 No requester valids SHALL produce m_X_valid=0 with pointer unchanged.

Reset
REQ-028 On rstn=0: locks cleared, RR pointers select requester 0 first, FIFO empty, rd_outstanding=0, err_orphan=0; while in reset, m_*_valid=0, all req_*_ready=0, req_rvalid=0.
REQ-029 Reset mid-transaction SHALL discard locked grants and in-flight read IDs; returns after reset are orphans (REQ-025).

Structure
REQ-030 ZONE_WIDTH, NUM_BANKS, DATA_WIDTH, ADDR_WIDTH defaults and wr/rd payload structs SHALL live in shared package accum_pkg.
REQ-031 SHALL instantiate sub-module rr_arbiter (NUM_REQ requests, lock input, one-hot grant) twice; ID FIFO inline.

Verification
REQ-032 req0, req1 write valid continuously, m_wr_ready=1 -> grants alternate 0,1,0,1; each req_wr_ready pulses every other cycle.
REQ-033 req1 write valid, m_wr_ready=0 for 3 cycles, req0 raises valid in cycle 2 -> grant stays 1, payload stable; req1 completes cycle 4, then req0.
REQ-034 Reads from req0 (addr 5), req1 (addr 9), req0 (addr 12); three m_rvalid pulses -> req_rvalid order 0,1,0; rd_outstanding 3->0.
REQ-035 RD_DEPTH=8 reads with no return -> 9th read blocked (m_rd_valid=0); one m_rvalid in the same cycle as the 9th request -> still blocked that cycle, accepted the next.
REQ-036 m_rvalid with empty FIFO -> no req_rvalid, err_orphan=1 held; deassert rstn -> err_orphan=0.
REQ-037 Simultaneous read push and return at occupancy 4 -> rd_outstanding stays 4, correct requester receives rvalid.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared accumulator-router defaults and the write/read payload layouts.
package accum_pkg;

  localparam int unsigned ACC_ZONE_WIDTH = 2;
  localparam int unsigned ACC_NUM_BANKS  = 4;
  localparam int unsigned ACC_DATA_WIDTH = 64;
  localparam int unsigned ACC_ADDR_WIDTH = 9;

  typedef struct packed {
    logic [ACC_ZONE_WIDTH-1:0]              zone_id;
    logic                                   accum_en;
    logic [ACC_NUM_BANKS-1:0]               mask;
    logic [ACC_ADDR_WIDTH-1:0]              addr;
    logic [ACC_NUM_BANKS*ACC_DATA_WIDTH-1:0] wdata;
  } acc_wr_t;

  typedef struct packed {
    logic [ACC_ZONE_WIDTH-1:0] zone_id;
    logic [ACC_NUM_BANKS-1:0]  mask;
    logic [ACC_ADDR_WIDTH-1:0] addr;
  } acc_rd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant; grant is held while the downstream stalls.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         hold,
  input  logic         done,
  output logic [N-1:0] grant
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          locked_q;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  pick;
  logic          found;
  int unsigned   idx;

  // First requesting index at or after the priority pointer.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        pick[IW'(idx)] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign grant = locked_q ? grant_q : pick;

  // Priority moves to the requester just after the one that completed.
  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (grant[k]) ptr_d = (k == N - 1) ? '0 : IW'(k + 1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q    <= '0;
      locked_q <= 1'b0;
      grant_q  <= '0;
    end else begin
      locked_q <= hold;
      grant_q  <= grant;
      if (done) ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/accum_arbiter.sv
// Shares one accumulator-router port among NUM_REQ requesters; reads return in order
// and are steered back to their issuer through an ID FIFO.
module accum_arbiter
  import accum_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ZONE_WIDTH = ACC_ZONE_WIDTH,
  parameter int unsigned NUM_BANKS  = ACC_NUM_BANKS,
  parameter int unsigned DATA_WIDTH = ACC_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = ACC_ADDR_WIDTH,
  parameter int unsigned RD_DEPTH   = 8
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic [NUM_REQ-1:0]                           req_wr_valid,
  output logic [NUM_REQ-1:0]                           req_wr_ready,
  input  logic [NUM_REQ-1:0][ZONE_WIDTH-1:0]           req_wr_zone_id,
  input  logic [NUM_REQ-1:0]                           req_accum_en,
  input  logic [NUM_REQ-1:0][NUM_BANKS-1:0]            req_wr_mask,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]           req_wr_addr,
  input  logic [NUM_REQ-1:0][NUM_BANKS*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]                           req_rd_valid,
  output logic [NUM_REQ-1:0]                           req_rd_ready,
  input  logic [NUM_REQ-1:0][ZONE_WIDTH-1:0]           req_rd_zone_id,
  input  logic [NUM_REQ-1:0][NUM_BANKS-1:0]            req_rd_mask,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]           req_rd_addr,
  output logic [NUM_REQ-1:0]                           req_rvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]              req_rdata,
  output logic                                         m_wr_valid,
  output logic                                         m_wvalid,
  input  logic                                         m_wr_ready,
  output logic [ZONE_WIDTH-1:0]                        m_wr_zone_id,
  output logic                                         m_accum_en,
  output logic [NUM_BANKS-1:0]                         m_wr_mask,
  output logic [ADDR_WIDTH-1:0]                        m_wr_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]              m_wdata,
  output logic                                         m_rd_valid,
  input  logic                                         m_rd_ready,
  output logic [ZONE_WIDTH-1:0]                        m_rd_zone_id,
  output logic [NUM_BANKS-1:0]                         m_rd_mask,
  output logic [ADDR_WIDTH-1:0]                        m_rd_addr,
  input  logic                                         m_rvalid,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]              m_rdata,
  output logic [$clog2(RD_DEPTH):0]                    rd_outstanding,
  output logic                                         err_orphan
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PW = $clog2(RD_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [NUM_REQ-1:0] wr_grant;
  logic [NUM_REQ-1:0] rd_grant;
  logic [IW-1:0]      wr_idx;
  logic [IW-1:0]      rd_idx;
  logic               wr_hold;
  logic               wr_done;
  logic               rd_hold;
  logic               rd_done;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [IW-1:0]      id_mem [RD_DEPTH];

  always_comb begin
    wr_idx = '0;
    rd_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_grant[i]) wr_idx = IW'(i);
      if (rd_grant[i]) rd_idx = IW'(i);
    end
  end

  // Write channel.
  assign m_wr_valid   = rstn & (|(wr_grant & req_wr_valid));
  assign m_wvalid     = m_wr_valid;
  assign m_wr_zone_id = req_wr_zone_id[wr_idx];
  assign m_accum_en   = req_accum_en[wr_idx];
  assign m_wr_mask    = req_wr_mask[wr_idx];
  assign m_wr_addr    = req_wr_addr[wr_idx];
  assign m_wdata      = req_wdata[wr_idx];
  assign req_wr_ready = rstn ? (wr_grant & {NUM_REQ{m_wr_ready}}) : '0;
  assign wr_hold      = m_wr_valid & ~m_wr_ready;
  assign wr_done      = m_wr_valid & m_wr_ready;

  // Read command channel; a full ID FIFO blocks issue regardless of a same-cycle pop.
  assign fifo_full    = (count_q == CW'(RD_DEPTH));
  assign m_rd_valid   = rstn & ~fifo_full & (|(rd_grant & req_rd_valid));
  assign m_rd_zone_id = req_rd_zone_id[rd_idx];
  assign m_rd_mask    = req_rd_mask[rd_idx];
  assign m_rd_addr    = req_rd_addr[rd_idx];
  assign req_rd_ready = (rstn && !fifo_full) ? (rd_grant & {NUM_REQ{m_rd_ready}}) : '0;
  assign rd_hold      = m_rd_valid & ~m_rd_ready;
  assign rd_done      = m_rd_valid & m_rd_ready;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (req_wr_valid),
    .hold (wr_hold),
    .done (wr_done),
    .grant(wr_grant)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (req_rd_valid),
    .hold (rd_hold),
    .done (rd_done),
    .grant(rd_grant)
  );

  // Read-return steering.
  assign push           = rd_done;
  assign pop            = rstn & m_rvalid & (count_q != '0);
  assign req_rdata      = m_rdata;
  assign rd_outstanding = count_q;

  always_comb begin
    req_rvalid = '0;
    if (pop) req_rvalid[id_mem[rd_ptr_q]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_q] <= rd_idx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (m_rvalid && count_q == '0) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accum_arbiter.sv
// Bench for accum_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_accum_arbiter;
  import accum_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned ZW = ACC_ZONE_WIDTH;
  localparam int unsigned NB = ACC_NUM_BANKS;
  localparam int unsigned DW = ACC_DATA_WIDTH;
  localparam int unsigned AW = ACC_ADDR_WIDTH;
  localparam int unsigned RD = 8;
  localparam int unsigned BW = NB * DW;
  localparam int unsigned OW = $clog2(RD) + 1;

  logic clk, rstn;
  logic [N-1:0] req_wr_valid, req_wr_ready, req_accum_en;
  logic [N-1:0][ZW-1:0] req_wr_zone_id, req_rd_zone_id;
  logic [N-1:0][NB-1:0] req_wr_mask, req_rd_mask;
  logic [N-1:0][AW-1:0] req_wr_addr, req_rd_addr;
  logic [N-1:0][BW-1:0] req_wdata;
  logic [N-1:0] req_rd_valid, req_rd_ready, req_rvalid;
  logic [BW-1:0] req_rdata, m_wdata, m_rdata;
  logic m_wr_valid, m_wvalid, m_wr_ready, m_accum_en, m_rd_valid, m_rd_ready, m_rvalid;
  logic [ZW-1:0] m_wr_zone_id, m_rd_zone_id;
  logic [NB-1:0] m_wr_mask, m_rd_mask;
  logic [AW-1:0] m_wr_addr, m_rd_addr;
  logic [OW-1:0] rd_outstanding;
  logic err_orphan;

  accum_arbiter #(.NUM_REQ(N), .RD_DEPTH(RD)) dut (
    .clk(clk), .rstn(rstn),
    .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready),
    .req_wr_zone_id(req_wr_zone_id), .req_accum_en(req_accum_en),
    .req_wr_mask(req_wr_mask), .req_wr_addr(req_wr_addr), .req_wdata(req_wdata),
    .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready),
    .req_rd_zone_id(req_rd_zone_id), .req_rd_mask(req_rd_mask), .req_rd_addr(req_rd_addr),
    .req_rvalid(req_rvalid), .req_rdata(req_rdata),
    .m_wr_valid(m_wr_valid), .m_wvalid(m_wvalid), .m_wr_ready(m_wr_ready),
    .m_wr_zone_id(m_wr_zone_id), .m_accum_en(m_accum_en), .m_wr_mask(m_wr_mask),
    .m_wr_addr(m_wr_addr), .m_wdata(m_wdata),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
    .m_rd_zone_id(m_rd_zone_id), .m_rd_mask(m_rd_mask), .m_rd_addr(m_rd_addr),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .rd_outstanding(rd_outstanding), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: last-served requester per channel, stall holder, queue of read issuers.
  int wr_last, rd_last, wr_who, rd_who;
  bit wr_lock, rd_lock, orphan;
  int fifo[$];
  bit [N-1:0] wr_acc, rd_acc;

  function automatic int pick(bit lock, int who, int last, logic [N-1:0] v);
    if (lock) return who;
    for (int k = 1; k <= int'(N); k++) begin
      int i;
      i = (last + k) % int'(N);
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    wr_last = int'(N) - 1;
    rd_last = int'(N) - 1;
    wr_lock = 1'b0;
    rd_lock = 1'b0;
    wr_who  = 0;
    rd_who  = 0;
    fifo.delete();
    orphan  = 1'b0;
  endtask

  // One clock: compare outputs at the falling edge, advance the model, return after the next rise.
  task automatic cycle();
    int ew, er;
    bit ewv, erv, pop;
    logic [N-1:0] ev;
    @(negedge clk);
    wr_acc = '0;
    rd_acc = '0;
    if (!rstn) begin
      check("rst_m_wr_valid", BW'(m_wr_valid), '0);
      check("rst_m_rd_valid", BW'(m_rd_valid), '0);
      check("rst_wr_ready", BW'(req_wr_ready), '0);
      check("rst_rd_ready", BW'(req_rd_ready), '0);
      check("rst_rvalid", BW'(req_rvalid), '0);
      check("rst_outstanding", BW'(rd_outstanding), '0);
      check("rst_err_orphan", BW'(err_orphan), '0);
      model_reset();
    end else begin
      ew  = pick(wr_lock, wr_who, wr_last, req_wr_valid);
      ewv = (ew >= 0);
      ev  = (ewv && m_wr_ready) ? (N'(1) << ew) : '0;
      check("m_wr_valid", BW'(m_wr_valid), BW'(ewv));
      check("m_wvalid", BW'(m_wvalid), BW'(ewv));
      check("req_wr_ready", BW'(req_wr_ready), BW'(ev));
      if (ewv) begin
        check("m_wr_zone_id", BW'(m_wr_zone_id), BW'(req_wr_zone_id[ew]));
        check("m_accum_en", BW'(m_accum_en), BW'(req_accum_en[ew]));
        check("m_wr_mask", BW'(m_wr_mask), BW'(req_wr_mask[ew]));
        check("m_wr_addr", BW'(m_wr_addr), BW'(req_wr_addr[ew]));
        check("m_wdata", m_wdata, req_wdata[ew]);
      end
      er  = pick(rd_lock, rd_who, rd_last, req_rd_valid);
      erv = (er >= 0) && (fifo.size() < int'(RD));
      ev  = (erv && m_rd_ready) ? (N'(1) << er) : '0;
      check("m_rd_valid", BW'(m_rd_valid), BW'(erv));
      check("req_rd_ready", BW'(req_rd_ready), BW'(ev));
      if (erv) begin
        check("m_rd_zone_id", BW'(m_rd_zone_id), BW'(req_rd_zone_id[er]));
        check("m_rd_mask", BW'(m_rd_mask), BW'(req_rd_mask[er]));
        check("m_rd_addr", BW'(m_rd_addr), BW'(req_rd_addr[er]));
      end
      pop = m_rvalid && (fifo.size() > 0);
      ev  = pop ? (N'(1) << fifo[0]) : '0;
      check("req_rvalid", BW'(req_rvalid), BW'(ev));
      check("req_rdata", req_rdata, m_rdata);
      check("rd_outstanding", BW'(rd_outstanding), BW'(fifo.size()));
      check("err_orphan", BW'(err_orphan), BW'(orphan));

      if (ewv && m_wr_ready) begin
        wr_last = ew; wr_lock = 1'b0; wr_acc[ew] = 1'b1;
      end else if (ewv) begin
        wr_lock = 1'b1; wr_who = ew;
      end else wr_lock = 1'b0;
      if (m_rvalid) begin
        if (pop) void'(fifo.pop_front());
        else orphan = 1'b1;
      end
      if (erv && m_rd_ready) begin
        rd_last = er; rd_lock = 1'b0; rd_acc[er] = 1'b1; fifo.push_back(er);
      end else if (erv) begin
        rd_lock = 1'b1; rd_who = er;
      end else rd_lock = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] rand_bw();
    logic [BW-1:0] r;
    for (int k = 0; k < int'(BW / 32); k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle();
    req_wr_valid = '0; req_rd_valid = '0;
    m_wr_ready = 1'b0; m_rd_ready = 1'b0; m_rvalid = 1'b0;
  endtask

  // Requesters hold valid and payload until accepted; the router side toggles randomly.
  task automatic drive_random();
    for (int i = 0; i < int'(N); i++) begin
      if (!req_wr_valid[i] || wr_acc[i]) begin
        req_wr_valid[i]   = ($urandom_range(2, 0) != 0);
        req_wr_zone_id[i] = ZW'($urandom);
        req_accum_en[i]   = 1'($urandom);
        req_wr_mask[i]    = NB'($urandom);
        req_wr_addr[i]    = AW'($urandom);
        req_wdata[i]      = rand_bw();
      end
      if (!req_rd_valid[i] || rd_acc[i]) begin
        req_rd_valid[i]   = ($urandom_range(2, 0) == 0);
        req_rd_zone_id[i] = ZW'($urandom);
        req_rd_mask[i]    = NB'($urandom);
        req_rd_addr[i]    = AW'($urandom);
      end
    end
    m_wr_ready = ($urandom_range(3, 0) != 0);
    m_rd_ready = ($urandom_range(3, 0) != 0);
    m_rvalid   = (fifo.size() > 0) ? ($urandom_range(2, 0) == 0) : ($urandom_range(40, 0) == 0);
    m_rdata    = rand_bw();
  endtask

  initial begin
    model_reset();
    idle();
    for (int i = 0; i < int'(N); i++) begin
      req_wr_zone_id[i] = ZW'(i + 1); req_accum_en[i] = 1'(i);
      req_wr_mask[i] = NB'(4'h3 << i); req_wr_addr[i] = AW'(100 + i);
      req_wdata[i] = rand_bw();
      req_rd_zone_id[i] = ZW'(i); req_rd_mask[i] = NB'(4'hf); req_rd_addr[i] = '0;
    end
    m_rdata = rand_bw();
    rstn = 1'b0;
    req_wr_valid = 2'b11; req_rd_valid = 2'b11; m_wr_ready = 1'b1; m_rd_ready = 1'b1;
    cycle(); cycle();
    rstn = 1'b1;
    idle();

    // Alternating write grants with both requesters always valid.
    req_wr_valid = 2'b11; m_wr_ready = 1'b1;
    repeat (4) cycle();
    idle(); cycle();

    // Stalled grant to req1 stays put when req0 arrives.
    req_wr_valid = 2'b10; cycle();
    req_wr_valid = 2'b11; cycle(); cycle();
    m_wr_ready = 1'b1; cycle();
    req_wr_valid = 2'b01; cycle();
    idle(); cycle();

    // Three reads returned in order.
    m_rd_ready = 1'b1;
    req_rd_addr[0] = AW'(5); req_rd_valid = 2'b01; cycle();
    req_rd_addr[1] = AW'(9); req_rd_valid = 2'b10; cycle();
    req_rd_addr[0] = AW'(12); req_rd_valid = 2'b01; cycle();
    req_rd_valid = '0; m_rvalid = 1'b1;
    repeat (3) cycle();
    idle(); cycle();

    // Fill the ID FIFO, then a ninth read with a same-cycle return.
    req_rd_valid = 2'b01; m_rd_ready = 1'b1;
    repeat (RD) cycle();
    m_rvalid = 1'b1; cycle();
    m_rvalid = 1'b0; cycle();
    req_rd_valid = '0; m_rvalid = 1'b1;
    repeat (4) cycle();
    // Push and pop together at occupancy 4.
    req_rd_valid = 2'b10; cycle();
    req_rd_valid = '0;
    repeat (4) cycle();

    // Orphan return is sticky until reset.
    cycle();
    m_rvalid = 1'b0; cycle(); cycle();
    rstn = 1'b0; cycle();
    rstn = 1'b1; cycle();

    for (int c = 0; c < 1500; c++) begin
      drive_random();
      if (c == 700) rstn = 1'b0;
      cycle();
      rstn = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
